// File: rtl/px_capture_if.sv
// Framebuffer write port: FIFO head entry offered with valid/ready backpressure.
interface px_capture_if;
  logic        fb_valid;
  logic        fb_ready;
  logic [15:0] fb_addr;
  logic [23:0] fb_rgb;

  modport master (output fb_valid, fb_addr, fb_rgb, input fb_ready);
  modport slave  (input fb_valid, fb_addr, fb_rgb, output fb_ready);
endinterface

// File: rtl/px_capture.sv
// PPU pixel capture: palette lookup, framebuffer addressing, write FIFO and frame checks.
// Define PX_CAPTURE_CRC_EN to add the per-frame CRC-16-CCITT output frame_crc.
module px_capture #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned H_PIXELS   = 256,
  parameter int unsigned V_LINES    = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pixel,
  input  logic        pixel_en,
  input  logic        frame,
  px_capture_if.master fb,
  output logic        frame_done,
  output logic [15:0] frame_count,
  input  logic        err_clr,
  output logic        err_short,
  output logic        err_overrun,
  output logic        err_overflow
`ifdef PX_CAPTURE_CRC_EN
  ,
  output logic [15:0] frame_crc
`endif
);

  localparam int unsigned XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int unsigned YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

  typedef enum logic [1:0] {WAIT_SYNC, ACTIVE, FULL} state_t;

  state_t        state_q, state_d, pos_state;
  logic [XW-1:0] x_q, x_d, cur_x;
  logic [YW-1:0] y_q, y_d, cur_y;
  logic          accept, close, short_set, overrun_set;
  logic [15:0]   addr_cur;

  logic          s1_valid_q;
  logic [5:0]    s1_idx_q;
  logic [15:0]   s1_addr_q;

  logic [15:0]   addr_mem_q [FIFO_DEPTH];
  logic [23:0]   rgb_mem_q  [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          empty, full, rd_en, wr_en, drop;

  logic          frame_done_q, err_short_q, err_overrun_q, err_overflow_q;
  logic [15:0]   frame_count_q;

  function automatic logic [23:0] palette(input logic [5:0] idx);
    case (idx)
      6'h00: palette = 24'h545454; 6'h01: palette = 24'h001E74; 6'h02: palette = 24'h081090; 6'h03: palette = 24'h300088;
      6'h04: palette = 24'h440064; 6'h05: palette = 24'h5C0030; 6'h06: palette = 24'h540400; 6'h07: palette = 24'h3C1800;
      6'h08: palette = 24'h202A00; 6'h09: palette = 24'h083A00; 6'h0A: palette = 24'h004000; 6'h0B: palette = 24'h003C00;
      6'h0C: palette = 24'h00323C; 6'h10: palette = 24'h989698; 6'h11: palette = 24'h084CC4; 6'h12: palette = 24'h3032EC;
      6'h13: palette = 24'h5C1EE4; 6'h14: palette = 24'h8814B0; 6'h15: palette = 24'hA01464; 6'h16: palette = 24'h982220;
      6'h17: palette = 24'h783C00; 6'h18: palette = 24'h545A00; 6'h19: palette = 24'h287200; 6'h1A: palette = 24'h087C00;
      6'h1B: palette = 24'h007628; 6'h1C: palette = 24'h006678; 6'h20: palette = 24'hFFFFFF; 6'h21: palette = 24'h4C9AEC;
      6'h22: palette = 24'h787CEC; 6'h23: palette = 24'hB062EC; 6'h24: palette = 24'hE454EC; 6'h25: palette = 24'hEC58B4;
      6'h26: palette = 24'hEC6A64; 6'h27: palette = 24'hD48820; 6'h28: palette = 24'hA0AA00; 6'h29: palette = 24'h74C400;
      6'h2A: palette = 24'h4CD020; 6'h2B: palette = 24'h38CC6C; 6'h2C: palette = 24'h38B4CC; 6'h2D: palette = 24'h3C3C3C;
      6'h30: palette = 24'hFFFFFF; 6'h31: palette = 24'hA8CCEC; 6'h32: palette = 24'hBCBCEC; 6'h33: palette = 24'hD4B2EC;
      6'h34: palette = 24'hECAEEC; 6'h35: palette = 24'hECAED4; 6'h36: palette = 24'hECB4B0; 6'h37: palette = 24'hE4C490;
      6'h38: palette = 24'hCCD278; 6'h39: palette = 24'hB4DE78; 6'h3A: palette = 24'hA8E290; 6'h3B: palette = 24'h98E2B4;
      6'h3C: palette = 24'hA0D6E4; 6'h3D: palette = 24'hA0A2A0;
      default: palette = 24'h000000;
    endcase
  endfunction

  // A same-cycle frame pulse is applied first, so the pixel is judged at the reset position.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    accept      = 1'b0;
    close       = 1'b0;
    short_set   = 1'b0;
    overrun_set = 1'b0;
    pos_state   = state_q;
    cur_x       = x_q;
    cur_y       = y_q;
    if (frame) begin
      close     = (state_q != WAIT_SYNC);
      short_set = (state_q == ACTIVE);
      pos_state = ACTIVE;
      cur_x     = '0;
      cur_y     = '0;
      state_d   = ACTIVE;
      x_d       = '0;
      y_d       = '0;
    end
    if (pixel_en) begin
      case (pos_state)
        ACTIVE: begin
          accept = 1'b1;
          if (cur_x == X_LAST) begin
            x_d = '0;
            if (cur_y == Y_LAST) begin
              y_d     = '0;
              state_d = FULL;
            end else begin
              y_d = cur_y + 1'b1;
            end
          end else begin
            x_d = cur_x + 1'b1;
          end
        end
        FULL:    overrun_set = 1'b1;
        default: ;
      endcase
    end
  end

  assign addr_cur = 16'(32'(cur_y) * H_PIXELS + 32'(cur_x));

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en = !empty && fb.fb_ready;
  assign wr_en = s1_valid_q && (!full || rd_en);
  assign drop  = s1_valid_q && full && !rd_en;

  assign fb.fb_valid = !empty;
  assign fb.fb_addr  = addr_mem_q[rd_ptr_q[AW-1:0]];
  assign fb.fb_rgb   = rgb_mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= WAIT_SYNC;
      x_q            <= '0;
      y_q            <= '0;
      s1_valid_q     <= 1'b0;
      s1_idx_q       <= '0;
      s1_addr_q      <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      frame_done_q   <= 1'b0;
      frame_count_q  <= '0;
      err_short_q    <= 1'b0;
      err_overrun_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        rgb_mem_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      s1_valid_q <= accept;
      if (accept) begin
        s1_idx_q  <= pixel[5:0];
        s1_addr_q <= addr_cur;
      end
      if (wr_en) begin
        addr_mem_q[wr_ptr_q[AW-1:0]] <= s1_addr_q;
        rgb_mem_q[wr_ptr_q[AW-1:0]]  <= palette(s1_idx_q);
        wr_ptr_q                     <= wr_ptr_q + 1'b1;
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      frame_done_q   <= close;
      frame_count_q  <= frame_count_q + 16'(close);
      err_short_q    <= short_set   || (err_short_q    && !err_clr);
      err_overrun_q  <= overrun_set || (err_overrun_q  && !err_clr);
      err_overflow_q <= drop        || (err_overflow_q && !err_clr);
    end
  end

  assign frame_done   = frame_done_q;
  assign frame_count  = frame_count_q;
  assign err_short    = err_short_q;
  assign err_overrun  = err_overrun_q;
  assign err_overflow = err_overflow_q;

`ifdef PX_CAPTURE_CRC_EN
  logic [15:0] crc_run_q, crc_run_d, crc_base, frame_crc_q;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int unsigned i = 0; i < 8; i++) r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction

  always_comb begin
    crc_base  = frame ? 16'hFFFF : crc_run_q;
    crc_run_d = accept ? crc_byte(crc_base, {2'b00, pixel[5:0]}) : crc_base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_run_q   <= 16'hFFFF;
      frame_crc_q <= '0;
    end else begin
      crc_run_q <= crc_run_d;
      if (close) frame_crc_q <= crc_run_q;
    end
  end

  assign frame_crc = frame_crc_q;
`endif

endmodule

// File: doc/px_capture.md
Name: px_capture

Overview:
- Downstream consumer of the PPU pixel stream (px_data, px_en, frame_sync).
- Converts each 6-bit palette index to 24-bit RGB through a fixed 2C02 palette.
- Generates the framebuffer address, y*256+x, and buffers writes in a small FIFO toward a framebuffer port that applies valid/ready backpressure.
- Checks frame geometry and reports errors, so the bench and the board design can tell whether the PPU produced a well-formed 256x240 frame.

Parameters:
- FIFO_DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- H_PIXELS, 256, pixels per line.
- V_LINES, 240, lines per frame.

Ports:
- clk  in  1  PPU pixel clock.
- rst  in  1  asynchronous, active-high reset.
- pixel  in  8  PPU pixel; bits [5:0] are the palette index, bits [7:6] are ignored.
- pixel_en  in  1  pixel valid strobe, one pixel per asserted cycle.
- frame  in  1  single-cycle frame-start pulse (PPU frame_sync).
- fb_ready  in  1  framebuffer accepts the head entry this cycle.
- fb_valid  out  1  FIFO head entry valid.
- fb_addr  out  16  pixel address, y*H_PIXELS + x.
- fb_rgb  out  24  {R,G,B}, 8 bits each.
- frame_done  out  1  one-cycle pulse when a frame is closed by the next frame pulse.
- frame_count  out  16  completed frames, wraps at 0xFFFF -> 0.
- err_clr  in  1  clears the sticky error flags.
- err_short  out  1  sticky: a frame closed with fewer than H_PIXELS*V_LINES pixels.
- err_overrun  out  1  sticky: a pixel arrived after the frame was already full.
- err_overflow  out  1  sticky: a pixel was dropped because the FIFO was full.

Behaviour:
- Reset values: all outputs 0, FIFO empty, x=y=0, FSM in WAIT_SYNC.
- FSM states: WAIT_SYNC, ACTIVE, FULL.
  - WAIT_SYNC: discard pixels; on frame go to ACTIVE with x=y=0. The first frame pulse after reset does not pulse frame_done and does not count.
  - ACTIVE: each pixel_en forwards the pixel at (x,y). x increments; when x reaches H_PIXELS-1 it wraps to 0 and y increments. After pixel (H_PIXELS-1, V_LINES-1) the FSM goes to FULL.
  - FULL: pixel_en drops the pixel and sets err_overrun.
- Frame pulse in ACTIVE or FULL:
  - pulse frame_done the next cycle and increment frame_count;
  - set err_short if the FSM is in ACTIVE (pixel count below the full frame);
  - reset x,y to 0 and enter ACTIVE.
- Simultaneous frame and pixel_en: the frame pulse is processed first; the pixel becomes (0,0) of the new frame and is not counted against the old frame.
- Pipeline:
  - Stage 1 registers the index and address.
  - Stage 2 performs the palette ROM lookup and writes the FIFO.
  - Empty FIFO with fb_ready=1: fb_valid rises 2 cycles after pixel_en.
  - Handshake: an entry is transferred when fb_valid & fb_ready. fb_addr and fb_rgb stay stable while fb_valid=1 and fb_ready=0.
- FIFO ordering:
  - A write and a read in the same cycle when full is allowed; the read frees the slot, so nothing is dropped.
  - A write when full with no read drops the new pixel and sets err_overflow.
- Palette:
  - Fixed 64-entry 2C02 table.
  - Indices 0x0D, 0x0E, 0x0F, 0x1E, 0x1F, 0x2E, 0x2F, 0x3E, 0x3F map to 0x000000.
  - Indices 0x20 and 0x30 map to 0xFFFFFF.
  - Index 0x00 maps to 0x545454.
- Errors: sticky flags are cleared by err_clr. A same-cycle set takes priority over clear.
- Reset mid-frame empties the FIFO at once, drops in-flight pixels and returns the FSM to WAIT_SYNC.
- The FIFO is not flushed on frame; entries drain normally.

Optional Feature:
- Macro PX_CAPTURE_CRC_EN.
- When defined:
  - adds output frame_crc (16 bits).
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF) over every accepted pixel index, zero-extended to 8 bits, in frame order.
  - frame_crc updates together with frame_done and holds until the next frame_done. Reset value 0.
- When undefined: the port and the logic are absent.

Test Plan:
- Reset, frame pulse, then 61440 pixels with index = x[5:0], fb_ready=1, then frame pulse:
  - 61440 writes in order, fb_addr 0..0xEFFF;
  - frame_done one pulse, frame_count=1;
  - no error flags set.
- Pixels before the first frame pulse after reset -> no fb_valid and no errors. Pixel index 0x30 at (0,0) of the next frame -> fb_rgb=0xFFFFFF, fb_addr=0x0000, fb_valid exactly 2 cycles after pixel_en.
- Hold fb_ready=0 and send 6 pixels with FIFO_DEPTH=4:
  - 4 entries held, err_overflow=1;
  - after fb_ready=1, addresses 0,1,2,3 drain in order with stable data;
  - err_clr clears the flag.
- Frame pulse after 1000 pixels -> err_short=1, frame_done pulse. The same-cycle pixel lands at fb_addr 0x0000.
- 61441 pixels in one frame -> err_overrun=1 and only 61440 writes.
- Assert rst mid-frame with 3 entries queued -> fb_valid=0 next cycle, frame_count=0; the next frame restarts at fb_addr 0. With PX_CAPTURE_CRC_EN, a full frame of index 0x00 gives frame_crc equal to the bench's software CRC model.
